// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-side memory/MMIO controller.
// Turns 16-bit byte-addressed CPU read/write strobes into word accesses on a
// synchronous RAM with fixed read latency, or into a small MMIO register file.
// Read data returns with a one-cycle valid pulse. Wait request is held while a
// read is outstanding.
//
// MMIO map (byte addresses):
//   0x8000 LED        RW  low LED_W bits
//   0x8002 switches   RO
//   0x8004 status     RO  bit0 = sticky error, cleared by reading it
//   0x8006 cycle lo   RO  also latches the counter high word
//   0x8008 cycle hi   RO  high word latched by the last 0x8006 read
//
// Build option: define MEM_CTRL_CYCLE_CNT_EN to build the 32-bit free-running
// cycle counter and its high-word latch. When the option is left undefined,
// 0x8006/0x8008 stay mapped read-only registers that return 0x0000.
//
// Parameter limits: RAM_LAT 1..3, RAM_AW <= 15, LED_W <= 16.

module mem_ctrl #(
    parameter int RAM_AW  = 12,
    parameter int RAM_LAT = 1,
    parameter int LED_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       i_mem_addr,
    input  logic              i_mem_rd,
    input  logic              i_mem_wr,
    input  logic [15:0]       i_mem_wrdata,
    output logic [15:0]       o_mem_rddata,
    output logic              o_mem_rddatavalid,
    output logic              o_waitrequest,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_wr,
    output logic [15:0]       o_ram_wrdata,
    input  logic [15:0]       i_ram_rddata,
    input  logic [15:0]       i_switches,
    output logic [LED_W-1:0]  o_leds
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    // MMIO register index taken from the word address bits [3:1].
    localparam logic [2:0] REG_LED    = 3'd0;
    localparam logic [2:0] REG_SW     = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CNT_LO = 3'd3;
    localparam logic [2:0] REG_CNT_HI = 3'd4;

    state_t            state_q, state_d;
    logic [1:0]        lat_q;
    logic [RAM_AW-1:0] addr_q;
    logic              error_q;
    logic [15:0]       mmio_rdata;
    logic [15:0]       cnt_lo;
    logic [15:0]       cnt_hi;

    // Byte-address bit 0 never selects anything. Word accesses only.
    logic unused_addr_bit0;
    assign unused_addr_bit0 = i_mem_addr[0];

    // Request decode. A new request is only accepted in IDLE.
    logic       is_mmio, mmio_hit, in_idle;
    logic       acc_wr, acc_rd, acc_both;
    logic       err_set, err_clr, cnt_lo_rd;
    logic [2:0] reg_sel;

    assign is_mmio  = i_mem_addr[15];
    assign reg_sel  = i_mem_addr[3:1];
    assign mmio_hit = (i_mem_addr[14:4] == '0) && (reg_sel <= REG_CNT_HI);
    assign in_idle  = (state_q == IDLE);
    assign acc_wr   = in_idle && i_mem_wr;
    assign acc_rd   = in_idle && i_mem_rd && !i_mem_wr;
    assign acc_both = in_idle && i_mem_rd && i_mem_wr;

    // The error flag is set by a simultaneous read and write, by a write to a
    // read-only or unmapped MMIO address, or by a read of an unmapped address.
    assign err_set = acc_both
                   || (acc_wr && is_mmio && !(mmio_hit && reg_sel == REG_LED))
                   || (acc_rd && is_mmio && !mmio_hit);
    assign err_clr   = acc_rd && is_mmio && mmio_hit && (reg_sel == REG_STATUS);
    assign cnt_lo_rd = acc_rd && is_mmio && mmio_hit && (reg_sel == REG_CNT_LO);

    assign o_ram_wrdata = i_mem_wrdata;

`ifdef MEM_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_q;
    logic [15:0] cyc_hi_q;

    // Free-running cycle counter. The high word is latched with every low-word
    // read so that a lo/hi read pair sees a consistent 32-bit value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            cyc_hi_q  <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (cnt_lo_rd)
                cyc_hi_q <= cyc_cnt_q[31:16];
        end
    end

    assign cnt_lo = cyc_cnt_q[15:0];
    assign cnt_hi = cyc_hi_q;
`else
    logic unused_cnt_lo_rd;
    assign unused_cnt_lo_rd = cnt_lo_rd;
    assign cnt_lo = '0;
    assign cnt_hi = '0;
`endif

    // MMIO read mux. Unmapped addresses read as zero.
    always_comb begin
        // NOTE: every combinational output gets a default before the case, so a
        // missing branch cannot infer a latch.
        mmio_rdata = '0;
        if (mmio_hit) begin
            case (reg_sel)
                REG_LED:    mmio_rdata = 16'(o_leds);
                REG_SW:     mmio_rdata = i_switches;
                REG_STATUS: mmio_rdata = {15'd0, error_q};
                REG_CNT_LO: mmio_rdata = cnt_lo;
                REG_CNT_HI: mmio_rdata = cnt_hi;
                default:    mmio_rdata = '0;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments, so every register in this
        // design samples pre-edge values regardless of block ordering.
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and handshake/RAM strobes.
    always_comb begin
        state_d           = state_q;
        o_waitrequest     = 1'b1;
        o_mem_rddatavalid = 1'b0;
        o_ram_wr          = 1'b0;
        o_ram_addr        = i_mem_addr[RAM_AW:1];
        case (state_q)
            IDLE: begin
                o_waitrequest = 1'b0;
                // The write reaches the RAM in the accept cycle itself. It is
                // gated by reset so that no write can slip through during reset.
                o_ram_wr      = i_mem_wr && !is_mmio && !reset;
                if (acc_rd)
                    state_d = is_mmio ? RESP : RD_WAIT;
            end
            RD_WAIT: begin
                o_ram_addr = addr_q;
                // lat_q reaches zero on this edge, so the RAM data is due now.
                if (lat_q == 2'd1)
                    state_d = RESP;
            end
            RESP: begin
                o_mem_rddatavalid = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read datapath: latency counter, held RAM address and returned data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q        <= '0;
            addr_q       <= '0;
            o_mem_rddata <= '0;
        end else begin
            if (acc_rd && !is_mmio) begin
                lat_q  <= 2'(RAM_LAT);
                addr_q <= i_mem_addr[RAM_AW:1];
            end else if (state_q == RD_WAIT) begin
                lat_q <= lat_q - 2'd1;
            end

            if (acc_rd && is_mmio)
                o_mem_rddata <= mmio_rdata;
            else if (state_q == RD_WAIT && lat_q == 2'd1)
                o_mem_rddata <= i_ram_rddata;
        end
    end

    // MMIO write-side registers: LEDs and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_leds  <= '0;
            error_q <= 1'b0;
        end else begin
            if (acc_wr && is_mmio && mmio_hit && reg_sel == REG_LED)
                o_leds <= i_mem_wrdata[LED_W-1:0];
            if (err_set)
                error_q <= 1'b1;
            else if (err_clr)
                error_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed, table-driven bench for mem_ctrl with RAM_LAT=2.
// Provides a behavioural RAM with 2-cycle read latency. It also keeps a
// reference cycle count so that the cycle-counter register reads can be checked.

module tb_mem_ctrl;

    localparam int RAM_AW  = 12;
    localparam int RAM_LAT = 2;
    localparam int LED_W   = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       i_mem_addr;
    logic              i_mem_rd;
    logic              i_mem_wr;
    logic [15:0]       i_mem_wrdata;
    logic [15:0]       o_mem_rddata;
    logic              o_mem_rddatavalid;
    logic              o_waitrequest;
    logic [RAM_AW-1:0] o_ram_addr;
    logic              o_ram_wr;
    logic [15:0]       o_ram_wrdata;
    logic [15:0]       i_ram_rddata;
    logic [15:0]       i_switches;
    logic [LED_W-1:0]  o_leds;

    mem_ctrl #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .LED_W(LED_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_mem_addr        (i_mem_addr),
        .i_mem_rd          (i_mem_rd),
        .i_mem_wr          (i_mem_wr),
        .i_mem_wrdata      (i_mem_wrdata),
        .o_mem_rddata      (o_mem_rddata),
        .o_mem_rddatavalid (o_mem_rddatavalid),
        .o_waitrequest     (o_waitrequest),
        .o_ram_addr        (o_ram_addr),
        .o_ram_wr          (o_ram_wr),
        .o_ram_wrdata      (o_ram_wrdata),
        .i_ram_rddata      (i_ram_rddata),
        .i_switches        (i_switches),
        .o_leds            (o_leds)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with two-cycle read latency.
    logic [15:0] ram [0:(1<<RAM_AW)-1];
    logic [15:0] pipe0, pipe1;
    always @(posedge clk) begin
        if (o_ram_wr)
            ram[o_ram_addr] <= o_ram_wrdata;
        pipe0 <= ram[o_ram_addr];
        pipe1 <= pipe0;
    end
    assign i_ram_rddata = pipe1;

    // Reference cycle count: edges since reset was released.
    logic [31:0] tb_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= '0;
        else       tb_cnt <= tb_cnt + 32'd1;
    end

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] last_rd = 16'h0000;

    task automatic check(input string what, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", what, idx, act, exp);
        end
    endtask

    // One CPU access: set up at a negedge, accepted at the next posedge, then
    // observe six cycles for wait request and the valid pulse.
    // exp_lat = cycle (counted from accept) of the valid pulse, 0 = no pulse.
    task automatic access(input int idx, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic exp_ramwr, input int exp_lat,
                          input logic [15:0] exp_data, input bit data_from_cnt,
                          input logic [LED_W-1:0] exp_leds);
        int          wr_hi;
        int          valid_at;
        int          valid_cnt;
        logic [15:0] exp_d;
        @(negedge clk);
        check("idle_waitreq", idx, o_waitrequest, 1'b0);
        i_mem_rd     = rd;
        i_mem_wr     = wr;
        i_mem_addr   = addr;
        i_mem_wrdata = wdata;
        exp_d = data_from_cnt ? tb_cnt[15:0] : exp_data;
        #1;
        check("ram_wr", idx, o_ram_wr, exp_ramwr);
        if (!addr[15])
            check("ram_addr", idx, o_ram_addr, addr[RAM_AW:1]);
        if (exp_ramwr)
            check("ram_wrdata", idx, o_ram_wrdata, wdata);
        @(posedge clk);
        #1;
        i_mem_rd     = 1'b0;
        i_mem_wr     = 1'b0;
        i_mem_addr   = 16'hFFFF;
        i_mem_wrdata = 16'h0000;
        wr_hi = 0; valid_at = 0; valid_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (o_waitrequest) wr_hi++;
            if (k == 1) begin
                check("leds", idx, o_leds, exp_leds);
                if (rd && !wr && !addr[15])
                    check("ram_addr_held", idx, o_ram_addr, addr[RAM_AW:1]);
            end
            if (o_mem_rddatavalid) begin
                valid_cnt++;
                valid_at = k;
                check("rddata", idx, o_mem_rddata, exp_d);
            end
        end
        check("valid_cycle", idx, valid_at, exp_lat);
        check("valid_count", idx, valid_cnt, (exp_lat != 0) ? 1 : 0);
        check("waitreq_cycles", idx, wr_hi, exp_lat);
        if (exp_lat != 0) last_rd = exp_d;
        check("rddata_hold", idx, o_mem_rddata, last_rd);
    endtask

    typedef struct {
        logic             rd;
        logic             wr;
        logic [15:0]      addr;
        logic [15:0]      wdata;
        logic [15:0]      sw;
        logic             exp_ramwr;
        int               exp_lat;
        logic [15:0]      exp_data;
        logic [LED_W-1:0] exp_leds;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // rd   wr    addr      wdata     sw        ramwr lat data      leds
        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b1, 0, 16'h0000, 10'h000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 3, 16'h1234, 10'h000};
        vecs[2]  = '{1'b0, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 0, 16'h0000, 10'h3FF};
        vecs[3]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1, 16'h03FF, 10'h3FF};
        vecs[4]  = '{1'b1, 1'b0, 16'h8002, 16'h0000, 16'hA5A5, 1'b0, 1, 16'hA5A5, 10'h3FF};
        vecs[5]  = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'hA5A5, 1'b0, 1, 16'h0000, 10'h3FF};
        vecs[6]  = '{1'b0, 1'b1, 16'h8002, 16'h1111, 16'hA5A5, 1'b0, 0, 16'h0000, 10'h3FF};
        vecs[7]  = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'hA5A5, 1'b0, 1, 16'h0001, 10'h3FF};
        vecs[8]  = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'hA5A5, 1'b0, 1, 16'h0000, 10'h3FF};
        vecs[9]  = '{1'b1, 1'b1, 16'h0020, 16'h00FF, 16'h5A5A, 1'b1, 0, 16'h0000, 10'h3FF};
        vecs[10] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 1'b0, 3, 16'h00FF, 10'h3FF};
        vecs[11] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0001, 10'h3FF};
        vecs[12] = '{1'b1, 1'b0, 16'h800A, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0000, 10'h3FF};
        vecs[13] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0001, 10'h3FF};
        vecs[14] = '{1'b0, 1'b1, 16'h800C, 16'h5555, 16'h5A5A, 1'b0, 0, 16'h0000, 10'h3FF};
        vecs[15] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0001, 10'h3FF};
        vecs[16] = '{1'b0, 1'b1, 16'h8006, 16'h0000, 16'h5A5A, 1'b0, 0, 16'h0000, 10'h3FF};
        vecs[17] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0001, 10'h3FF};
        vecs[18] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0000, 10'h3FF};
        vecs[19] = '{1'b0, 1'b1, 16'h0FFE, 16'hBEEF, 16'h5A5A, 1'b1, 0, 16'h0000, 10'h3FF};
        vecs[20] = '{1'b1, 1'b0, 16'h0FFF, 16'h0000, 16'h5A5A, 1'b0, 3, 16'hBEEF, 10'h3FF};
        vecs[21] = '{1'b0, 1'b1, 16'h8000, 16'h0155, 16'h5A5A, 1'b0, 0, 16'h0000, 10'h155};
        vecs[22] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0155, 10'h155};
        vecs[23] = '{1'b1, 1'b0, 16'h8010, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0000, 10'h155};
        vecs[24] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0001, 10'h155};
        vecs[25] = '{1'b0, 1'b1, 16'h8010, 16'h0000, 16'h5A5A, 1'b0, 0, 16'h0000, 10'h155};
        vecs[26] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h5A5A, 1'b0, 1, 16'h0001, 10'h155};

        // Reset with a write strobe asserted: nothing may reach the RAM.
        reset        = 1'b1;
        i_mem_rd     = 1'b0;
        i_mem_wr     = 1'b1;
        i_mem_addr   = 16'h0000;
        i_mem_wrdata = 16'hDEAD;
        i_switches   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_rddata", 0, o_mem_rddata, 16'h0000);
        check("rst_valid", 0, o_mem_rddatavalid, 1'b0);
        check("rst_waitreq", 0, o_waitrequest, 1'b0);
        check("rst_leds", 0, o_leds, 10'h000);
        check("rst_ram_wr", 0, o_ram_wr, 1'b0);
        i_mem_wr = 1'b0;
        reset    = 1'b0;

        for (int i = 0; i < NV; i++) begin
            i_switches = vecs[i].sw;
            access(i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_ramwr, vecs[i].exp_lat, vecs[i].exp_data, 1'b0,
                   vecs[i].exp_leds);
        end

        // Reset in the middle of a RAM read.
        begin : reset_mid_read
            int valid_seen;
            @(negedge clk);
            i_mem_rd   = 1'b1;
            i_mem_addr = 16'h0010;
            @(posedge clk);
            #1;
            i_mem_rd   = 1'b0;
            i_mem_addr = 16'h0000;
            @(negedge clk);
            check("mid_rd_waitreq", 100, o_waitrequest, 1'b1);
            reset = 1'b1;
            #1;
            check("mid_rst_valid", 100, o_mem_rddatavalid, 1'b0);
            check("mid_rst_waitreq", 100, o_waitrequest, 1'b0);
            check("mid_rst_rddata", 100, o_mem_rddata, 16'h0000);
            check("mid_rst_leds", 100, o_leds, 10'h000);
            check("mid_rst_ram_wr", 100, o_ram_wr, 1'b0);
            check("mid_rst_ram_addr", 100, o_ram_addr, 12'h000);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            last_rd = 16'h0000;
            valid_seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (o_mem_rddatavalid) valid_seen++;
            end
            check("post_rst_no_valid", 100, valid_seen, 0);
            access(101, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 3, 16'h1234, 1'b0, 10'h000);
        end

        // Cycle counter: run freely, then read the low word and the latched high word.
        repeat (100) @(posedge clk);
`ifdef MEM_CTRL_CYCLE_CNT_EN
        access(102, 1'b1, 1'b0, 16'h8006, 16'h0000, 1'b0, 1, 16'h0000, 1'b1, 10'h000);
`else
        access(102, 1'b1, 1'b0, 16'h8006, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 10'h000);
`endif
        access(103, 1'b1, 1'b0, 16'h8008, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 10'h000);
        // Both counter reads are mapped, so the error flag must still be clear.
        access(104, 1'b1, 1'b0, 16'h8004, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
